// File: rtl/ifmap_load_seq.sv
// Transmitter for the IMEM ifmap load protocol: one load_start token, a
// (timestep, addr, data) triple per pixel per timestep, then one load_done token.
module ifmap_load_seq #(
   parameter int DEPTH_I = 25,
   parameter int NUM_TS  = 2,
   parameter int WIDTH   = 33,
   parameter int DATA_W  = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              go,
   output logic              busy,
   output logic              done,
   input  logic              src_valid,
   output logic              src_ready,
   input  logic [DATA_W-1:0] src_data,
   output logic              ls_valid,
   input  logic              ls_ready,
   output logic [WIDTH-1:0]  ls_data,
   output logic              ts_valid,
   input  logic              ts_ready,
   output logic [WIDTH-1:0]  ts_data,
   output logic              addr_valid,
   input  logic              addr_ready,
   output logic [WIDTH-1:0]  addr_data,
   output logic              data_valid,
   input  logic              data_ready,
   output logic [WIDTH-1:0]  data_data,
   output logic              ld_valid,
   input  logic              ld_ready,
   output logic [WIDTH-1:0]  ld_data
);

   localparam int NPIX = DEPTH_I * DEPTH_I;
   localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
   localparam int TW   = (NUM_TS > 1) ? $clog2(NUM_TS) : 1;
   localparam logic [AW-1:0] ADDR_LAST = AW'(NPIX - 1);
   localparam logic [TW-1:0] TS_LAST   = TW'(NUM_TS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      FETCH     = 3'd2,
      SEND_TS   = 3'd3,
      SEND_ADDR = 3'd4,
      SEND_DATA = 3'd5,
      FINISH    = 3'd6
   } state_t;

   state_t        r_state;
   logic [AW-1:0] r_addr_cnt;
   logic [TW-1:0] r_ts_cnt;

   // Sequencer: each state's outputs are registered on the transition into it,
   // so exactly one channel is offered at a time.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_addr_cnt <= '0;
         r_ts_cnt   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         src_ready  <= 1'b0;
         ls_valid   <= 1'b0;
         ts_valid   <= 1'b0;
         addr_valid <= 1'b0;
         data_valid <= 1'b0;
         ld_valid   <= 1'b0;
         ls_data    <= '0;
         ts_data    <= '0;
         addr_data  <= '0;
         data_data  <= '0;
         ld_data    <= '0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (go) begin
                  r_state  <= START;
                  busy     <= 1'b1;
                  ls_valid <= 1'b1;
                  ls_data  <= WIDTH'(1);
               end
            end
            START: begin
               if (ls_valid && ls_ready) begin
                  ls_valid   <= 1'b0;
                  r_ts_cnt   <= '0;
                  r_addr_cnt <= '0;
                  src_ready  <= 1'b1;
                  r_state    <= FETCH;
               end
            end
            FETCH: begin
               if (src_valid && src_ready) begin
                  src_ready <= 1'b0;
                  data_data <= WIDTH'(src_data);
                  ts_valid  <= 1'b1;
                  ts_data   <= WIDTH'(r_ts_cnt);
                  r_state   <= SEND_TS;
               end
            end
            SEND_TS: begin
               if (ts_valid && ts_ready) begin
                  ts_valid   <= 1'b0;
                  addr_valid <= 1'b1;
                  addr_data  <= WIDTH'(r_addr_cnt);
                  r_state    <= SEND_ADDR;
               end
            end
            SEND_ADDR: begin
               if (addr_valid && addr_ready) begin
                  addr_valid <= 1'b0;
                  data_valid <= 1'b1;
                  r_state    <= SEND_DATA;
               end
            end
            SEND_DATA: begin
               if (data_valid && data_ready) begin
                  data_valid <= 1'b0;
                  if (r_addr_cnt < ADDR_LAST) begin
                     r_addr_cnt <= r_addr_cnt + AW'(1);
                     src_ready  <= 1'b1;
                     r_state    <= FETCH;
                  end else if (r_ts_cnt < TS_LAST) begin
                     r_ts_cnt   <= r_ts_cnt + TW'(1);
                     r_addr_cnt <= '0;
                     src_ready  <= 1'b1;
                     r_state    <= FETCH;
                  end else begin
                     ld_valid <= 1'b1;
                     ld_data  <= WIDTH'(1);
                     r_state  <= FINISH;
                  end
               end
            end
            FINISH: begin
               if (ld_valid && ld_ready) begin
                  ld_valid <= 1'b0;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  r_state  <= IDLE;
               end
            end
            default: begin
               r_state    <= IDLE;
               busy       <= 1'b0;
               src_ready  <= 1'b0;
               ls_valid   <= 1'b0;
               ts_valid   <= 1'b0;
               addr_valid <= 1'b0;
               data_valid <= 1'b0;
               ld_valid   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ifmap_load_seq.sv
// Bench for ifmap_load_seq: a 2x2/2-timestep instance and a 1x1/1-timestep
// instance, each checked against a queue of expected tokens.
module tb_ifmap_load_seq;

   typedef struct {
      int          ch;
      logic [32:0] val;
   } tok_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, go, busy, done, src_valid, src_ready;
   logic [24:0] src_data;
   logic        ls_valid, ls_ready, ts_valid, ts_ready, addr_valid, addr_ready;
   logic        data_valid, data_ready, ld_valid, ld_ready;
   logic [32:0] ls_data, ts_data, addr_data, data_data, ld_data;

   logic        b_go, b_busy, b_done, b_src_valid, b_src_ready;
   logic [24:0] b_src_data;
   logic        b_ls_valid, b_ts_valid, b_addr_valid, b_data_valid, b_ld_valid;
   logic [32:0] b_ls_data, b_ts_data, b_addr_data, b_data_data, b_ld_data;

   int   checks = 0, errors = 0;
   int   n_src, n_addr, n_ls, n_trip, n_ld, n_done, n_busy;
   int   b_n_done, b_n_trip;
   tok_t exp_q[$];
   tok_t exp1_q[$];

   ifmap_load_seq #(.DEPTH_I(2), .NUM_TS(2), .WIDTH(33), .DATA_W(25)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .busy(busy), .done(done),
      .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
      .ls_valid(ls_valid), .ls_ready(ls_ready), .ls_data(ls_data),
      .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_data(ts_data),
      .addr_valid(addr_valid), .addr_ready(addr_ready), .addr_data(addr_data),
      .data_valid(data_valid), .data_ready(data_ready), .data_data(data_data),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data)
   );

   ifmap_load_seq #(.DEPTH_I(1), .NUM_TS(1), .WIDTH(33), .DATA_W(25)) dut1 (
      .clk(clk), .rst_n(rst_n), .go(b_go), .busy(b_busy), .done(b_done),
      .src_valid(b_src_valid), .src_ready(b_src_ready), .src_data(b_src_data),
      .ls_valid(b_ls_valid), .ls_ready(1'b1), .ls_data(b_ls_data),
      .ts_valid(b_ts_valid), .ts_ready(1'b1), .ts_data(b_ts_data),
      .addr_valid(b_addr_valid), .addr_ready(1'b1), .addr_data(b_addr_data),
      .data_valid(b_data_valid), .data_ready(1'b1), .data_data(b_data_data),
      .ld_valid(b_ld_valid), .ld_ready(1'b1), .ld_data(b_ld_data)
   );

   // Main-instance monitor: a transfer is seen on the falling edge before the rising edge that takes it
   always @(negedge clk) begin
      int          got_ch;
      logic [32:0] got_v;
      tok_t        e;
      if (rst_n) begin
         got_ch = -1;
         got_v  = '0;
         if (busy) n_busy++;
         if (done) n_done++;
         checks++;
         if ($countones({ls_valid, ts_valid, addr_valid, data_valid, ld_valid, src_ready}) > 1) begin
            errors++;
            $display("FAIL one_active got=%b required at most one bit set",
                     {ls_valid, ts_valid, addr_valid, data_valid, ld_valid, src_ready});
         end
         if (src_valid && src_ready) n_src++;
         if (ls_valid && ls_ready) begin got_ch = 0; got_v = ls_data; n_ls++; end
         else if (ts_valid && ts_ready) begin got_ch = 1; got_v = ts_data; end
         else if (addr_valid && addr_ready) begin got_ch = 2; got_v = addr_data; n_addr++; end
         else if (data_valid && data_ready) begin got_ch = 3; got_v = data_data; n_trip++; end
         else if (ld_valid && ld_ready) begin got_ch = 4; got_v = ld_data; n_ld++; end
         if (got_ch >= 0) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL token_extra got ch=%0d val=%0d required no token", got_ch, got_v);
            end else begin
               e = exp_q.pop_front();
               if (got_ch != e.ch || got_v !== e.val) begin
                  errors++;
                  $display("FAIL token got ch=%0d val=%0d required ch=%0d val=%0d",
                           got_ch, got_v, e.ch, e.val);
               end
            end
         end
      end
   end

   // Monitor for the single-pixel instance (all its readys are tied high)
   always @(negedge clk) begin
      int          got_ch;
      logic [32:0] got_v;
      tok_t        e;
      if (rst_n) begin
         got_ch = -1;
         got_v  = '0;
         if (b_done) b_n_done++;
         if (b_ls_valid) begin got_ch = 0; got_v = b_ls_data; end
         else if (b_ts_valid) begin got_ch = 1; got_v = b_ts_data; end
         else if (b_addr_valid) begin got_ch = 2; got_v = b_addr_data; end
         else if (b_data_valid) begin got_ch = 3; got_v = b_data_data; b_n_trip++; end
         else if (b_ld_valid) begin got_ch = 4; got_v = b_ld_data; end
         if (got_ch >= 0) begin
            checks++;
            if (exp1_q.size() == 0) begin
               errors++;
               $display("FAIL single_extra got ch=%0d val=%0d required no token", got_ch, got_v);
            end else begin
               e = exp1_q.pop_front();
               if (got_ch != e.ch || got_v !== e.val) begin
                  errors++;
                  $display("FAIL single_token got ch=%0d val=%0d required ch=%0d val=%0d",
                           got_ch, got_v, e.ch, e.val);
               end
            end
         end
      end
   end

   task automatic push_run(input int base);
      exp_q.push_back('{0, 33'd1});
      for (int t = 0; t < 2; t++) begin
         for (int p = 0; p < 4; p++) begin
            exp_q.push_back('{1, 33'(t)});
            exp_q.push_back('{2, 33'(p)});
            exp_q.push_back('{3, 33'(base + t * 4 + p)});
         end
      end
      exp_q.push_back('{4, 33'd1});
   endtask

   task automatic clear_counts();
      n_src = 0; n_addr = 0; n_ls = 0; n_trip = 0; n_ld = 0; n_done = 0; n_busy = 0;
   endtask

   // Full run on the main instance with optional src stall, addr backpressure and stray go pulses
   task automatic run_a(input int base, input int stall_len, input int bp_len,
                        input bit go_mid, input bit go_at_ld);
      int stall_done = 0, bp_done = 0, cyc = 0;
      bit fin = 1'b0;
      clear_counts();
      push_run(base);
      go = 1'b1;
      while (!fin && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         go = (go_mid && cyc == 12) || (go_at_ld && ld_valid);
         src_data = 25'(base + n_src);
         if (stall_len > 0 && n_src == 1 && stall_done < stall_len && (stall_done > 0 || src_ready)) begin
            checks++;
            if (src_ready !== 1'b1 || ts_valid || addr_valid || data_valid) begin
               errors++;
               $display("FAIL src_stall got src_ready=%b ts/addr/data_valid=%b%b%b required 1 000",
                        src_ready, ts_valid, addr_valid, data_valid);
            end
            src_valid = 1'b0;
            stall_done++;
         end else begin
            src_valid = 1'b1;
         end
         if (bp_len > 0 && bp_done < bp_len && (bp_done > 0 || (addr_valid && n_addr == 2))) begin
            checks++;
            if (addr_valid !== 1'b1 || addr_data !== 33'd2 ||
                ls_valid || ts_valid || data_valid || ld_valid || src_ready) begin
               errors++;
               $display("FAIL bp_hold got addr_valid=%b addr_data=%0d others=%b%b%b%b%b required 1 2 00000",
                        addr_valid, addr_data, ls_valid, ts_valid, data_valid, ld_valid, src_ready);
            end
            addr_ready = 1'b0;
            bp_done++;
         end else begin
            addr_ready = 1'b1;
         end
         if (done) fin = 1'b1;
      end
      go = 1'b0;
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL run_timeout got done=0 after %0d cycles required done pulse", cyc);
      end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         src_valid = 1'b1;
         checks++;
         if (busy || ls_valid || src_ready || ts_valid) begin
            errors++;
            $display("FAIL idle got busy=%b ls_valid=%b src_ready=%b ts_valid=%b required 0000",
                     busy, ls_valid, src_ready, ts_valid);
         end
      end
      src_valid = 1'b0;
      checks++;
      if (exp_q.size() != 0 || n_ls != 1 || n_trip != 8 || n_ld != 1 || n_done != 1) begin
         errors++;
         $display("FAIL counts got left=%0d ls=%0d trip=%0d ld=%0d done=%0d required 0 1 8 1 1",
                  exp_q.size(), n_ls, n_trip, n_ld, n_done);
      end
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if ({ls_valid, ts_valid, addr_valid, data_valid, ld_valid, busy, done, src_ready} !== 8'd0 ||
          {ls_data, ts_data, addr_data, data_data, ld_data} !== 165'd0) begin
         errors++;
         $display("FAIL reset_state got ctrl=%b required 00000000 with all data 0",
                  {ls_valid, ts_valid, addr_valid, data_valid, ld_valid, busy, done, src_ready});
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      // src_valid while idle must not wake the sequencer
      src_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (src_ready || busy || ls_valid) begin
         errors++;
         $display("FAIL idle_src got src_ready=%b busy=%b ls_valid=%b required 000", src_ready, busy, ls_valid);
      end
      src_valid = 1'b0;
   endtask

   task automatic test_basic();
      run_a(10, 0, 0, 1'b0, 1'b0);
      checks++;
      if (n_busy != 34) begin
         errors++;
         $display("FAIL busy_span got %0d cycles required 34", n_busy);
      end
   endtask

   task automatic test_backpressure();
      run_a(20, 0, 3, 1'b0, 1'b0);
   endtask

   task automatic test_src_stall();
      run_a(30, 5, 0, 1'b0, 1'b0);
   endtask

   task automatic test_go_ignore();
      run_a(40, 0, 0, 1'b1, 1'b1);
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      clear_counts();
      push_run(60);
      go = 1'b1;
      src_valid = 1'b1;
      while (!(addr_valid && n_trip >= 4) && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         go = 1'b0;
         src_data = 25'(60 + n_src);
      end
      checks++;
      if (!(addr_valid && n_trip >= 4)) begin
         errors++;
         $display("FAIL reset_mid_reach got addr_valid=%b trip=%0d required 1 >=4", addr_valid, n_trip);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ls_valid, ts_valid, addr_valid, data_valid, ld_valid, busy, done, src_ready} !== 8'd0) begin
         errors++;
         $display("FAIL reset_mid got ctrl=%b required 00000000",
                  {ls_valid, ts_valid, addr_valid, data_valid, ld_valid, busy, done, src_ready});
      end
      src_valid = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      run_a(50, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_single();
      int cyc = 0;
      bit fin = 1'b0;
      b_n_done = 0;
      b_n_trip = 0;
      exp1_q.push_back('{0, 33'd1});
      exp1_q.push_back('{1, 33'd0});
      exp1_q.push_back('{2, 33'd0});
      exp1_q.push_back('{3, 33'd7});
      exp1_q.push_back('{4, 33'd1});
      b_src_data  = 25'd7;
      b_src_valid = 1'b1;
      b_go        = 1'b1;
      while (!fin && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         b_go = 1'b0;
         if (b_done) fin = 1'b1;
      end
      b_src_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (!fin || b_n_done != 1 || b_n_trip != 1 || exp1_q.size() != 0 || b_busy) begin
         errors++;
         $display("FAIL single_run got fin=%b done=%0d trip=%0d left=%0d busy=%b required 1 1 1 0 0",
                  fin, b_n_done, b_n_trip, exp1_q.size(), b_busy);
      end
   endtask

   initial begin
      rst_n = 1'b0; go = 1'b0; src_valid = 1'b0; src_data = '0;
      ls_ready = 1'b1; ts_ready = 1'b1; addr_ready = 1'b1; data_ready = 1'b1; ld_ready = 1'b1;
      b_go = 1'b0; b_src_valid = 1'b0; b_src_data = '0;
      b_n_done = 0; b_n_trip = 0;
      clear_counts();
      test_reset();
      test_basic();
      test_backpressure();
      test_src_stall();
      test_go_ignore();
      test_reset_mid();
      test_single();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
